// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic safety monitor.
//   - Light encoding constants (one-hot red/yellow/green plus dark).
//   - Fault code constants, ordered by priority (lowest code wins).
//   - FSM state type and light classification helpers.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

    localparam logic [2:0] FAULT_NONE           = 3'd0;
    localparam logic [2:0] FAULT_CONFLICT       = 3'd1;
    localparam logic [2:0] FAULT_ENCODING       = 3'd2;
    localparam logic [2:0] FAULT_SKIPPED_YELLOW = 3'd3;
    localparam logic [2:0] FAULT_SHORT_YELLOW   = 3'd4;
    localparam logic [2:0] FAULT_SEQUENCE       = 3'd5;

    typedef enum logic {StNormal, StFault} state_e;

    // True only for the three legal one-hot colours.
    function automatic logic is_one_hot(input logic [2:0] light);
        return (light == LIGHT_RED) || (light == LIGHT_YELLOW) || (light == LIGHT_GREEN);
    endfunction

    // Approach is letting traffic move (green or yellow).
    function automatic logic is_go(input logic [2:0] light);
        return (light == LIGHT_GREEN) || (light == LIGHT_YELLOW);
    endfunction

endpackage

// File: rtl/traffic_safety_monitor_if.sv
// Bundle between the light controller and the safety monitor.
//   master : controller side, drives the four light vectors, observes lamps/fault.
//   slave  : monitor side, consumes light vectors, drives lamps, fault, fault_code.
interface traffic_safety_monitor_if;
    logic [2:0] north_light;
    logic [2:0] south_light;
    logic [2:0] east_light;
    logic [2:0] west_light;
    logic [2:0] north_lamp;
    logic [2:0] south_lamp;
    logic [2:0] east_lamp;
    logic [2:0] west_lamp;
    logic       fault;
    logic [2:0] fault_code;

    modport master (
        output north_light, south_light, east_light, west_light,
        input  north_lamp, south_lamp, east_lamp, west_lamp, fault, fault_code
    );

    modport slave (
        input  north_light, south_light, east_light, west_light,
        output north_lamp, south_lamp, east_lamp, west_lamp, fault, fault_code
    );
endinterface

// File: rtl/traffic_yellow_timer.sv
// Per-approach colour-sequence checker (built only with TRAFFIC_MONITOR_YELLOW_CHECK_EN).
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   enable       : advance history (held while the monitor is faulted)
//   light        : current controller colour for this approach
//   skipped      : green -> red this cycle
//   short_yellow : yellow -> red after fewer than MIN_YELLOW yellow cycles
//   sequence_err : red -> yellow or yellow -> green this cycle
module traffic_yellow_timer
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] light,
    output logic       skipped,
    output logic       short_yellow,
    output logic       sequence_err
);
    localparam int unsigned CW = $clog2(MIN_YELLOW + 1);

    logic [2:0]    prev_q;
    logic [CW-1:0] ycnt_q;
    logic [CW-1:0] ycnt_d;

    // Counter holds the number of consecutive yellow cycles seen so far,
    // so at the yellow->red cycle it equals the full yellow duration.
    always_comb begin
        ycnt_d = '0;
        if (light == LIGHT_YELLOW) begin
            if (prev_q != LIGHT_YELLOW) begin
                ycnt_d = CW'(1);
            end else if (ycnt_q < CW'(MIN_YELLOW)) begin
                ycnt_d = ycnt_q + CW'(1);
            end else begin
                ycnt_d = ycnt_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= LIGHT_RED;
            ycnt_q <= '0;
        end else if (enable) begin
            prev_q <= light;
            ycnt_q <= ycnt_d;
        end
    end

    assign skipped      = (prev_q == LIGHT_GREEN) && (light == LIGHT_RED);
    assign short_yellow = (prev_q == LIGHT_YELLOW) && (light == LIGHT_RED)
                          && (ycnt_q < CW'(MIN_YELLOW));
    assign sequence_err = ((prev_q == LIGHT_RED) && (light == LIGHT_YELLOW))
                          || ((prev_q == LIGHT_YELLOW) && (light == LIGHT_GREEN));
endmodule

// File: rtl/traffic_safety_monitor.sv
// Last sequential stage before the lamp drivers. Re-drives controller lights through
// one register; on any unsafe/malformed pattern latches a fault code and flashes all
// lamps red until reset.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus          : traffic_safety_monitor_if.slave (lights in; lamps, fault, fault_code out)
// Configuration macro: TRAFFIC_MONITOR_YELLOW_CHECK_EN enables the skipped-yellow,
// short-yellow and sequence checks (codes 3-5); otherwise only conflict and encoding.
module traffic_safety_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned FLASH_HALF = 8
) (
    input logic                   clock,
    input logic                   reset,
    traffic_safety_monitor_if.slave bus
);
    localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    if (MIN_YELLOW < 1 || FLASH_HALF < 1) begin : g_param_check
        $error("MIN_YELLOW and FLASH_HALF must be at least 1");
    end

    logic [2:0] light [4];
    logic [2:0] lamp_q [4];
    state_e     state_q;
    logic       fault_q;
    logic [2:0] code_q;
    logic [FW-1:0] flash_cnt_q;
    logic       flash_on_q;
    logic [2:0] viol_code;

    // Index order: north, south (axis A), east, west (axis B).
    assign light[0] = bus.north_light;
    assign light[1] = bus.south_light;
    assign light[2] = bus.east_light;
    assign light[3] = bus.west_light;

    logic [3:0] skipped;
    logic [3:0] short_yellow;
    logic [3:0] sequence_err;

`ifdef TRAFFIC_MONITOR_YELLOW_CHECK_EN
    for (genvar i = 0; i < 4; i++) begin : g_timer
        traffic_yellow_timer #(
            .MIN_YELLOW (MIN_YELLOW)
        ) u_timer (
            .clock        (clock),
            .reset        (reset),
            .enable       (state_q == StNormal),
            .light        (light[i]),
            .skipped      (skipped[i]),
            .short_yellow (short_yellow[i]),
            .sequence_err (sequence_err[i])
        );
    end
`else
    assign skipped      = '0;
    assign short_yellow = '0;
    assign sequence_err = '0;
`endif

    // Priority encode: lowest code wins when several checks fire together.
    always_comb begin
        viol_code = FAULT_NONE;
        if ((is_go(light[0]) || is_go(light[1])) && (is_go(light[2]) || is_go(light[3]))) begin
            viol_code = FAULT_CONFLICT;
        end else if (!(is_one_hot(light[0]) && is_one_hot(light[1])
                       && is_one_hot(light[2]) && is_one_hot(light[3]))) begin
            viol_code = FAULT_ENCODING;
        end else if (|skipped) begin
            viol_code = FAULT_SKIPPED_YELLOW;
        end else if (|short_yellow) begin
            viol_code = FAULT_SHORT_YELLOW;
        end else if (|sequence_err) begin
            viol_code = FAULT_SEQUENCE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StNormal;
            fault_q     <= 1'b0;
            code_q      <= FAULT_NONE;
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b1;
            for (int i = 0; i < 4; i++) lamp_q[i] <= LIGHT_RED;
        end else begin
            unique case (state_q)
                StNormal: begin
                    if (viol_code != FAULT_NONE) begin
                        // Violating pattern is never driven: lamps go straight to red.
                        state_q     <= StFault;
                        fault_q     <= 1'b1;
                        code_q      <= viol_code;
                        flash_cnt_q <= '0;
                        flash_on_q  <= 1'b1;
                        for (int i = 0; i < 4; i++) lamp_q[i] <= LIGHT_RED;
                    end else begin
                        for (int i = 0; i < 4; i++) lamp_q[i] <= light[i];
                    end
                end
                StFault: begin
                    if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
                        flash_cnt_q <= '0;
                        flash_on_q  <= !flash_on_q;
                        for (int i = 0; i < 4; i++) begin
                            lamp_q[i] <= flash_on_q ? LIGHT_OFF : LIGHT_RED;
                        end
                    end else begin
                        flash_cnt_q <= flash_cnt_q + FW'(1);
                    end
                end
                default: state_q <= StNormal;
            endcase
        end
    end

    assign bus.north_lamp = lamp_q[0];
    assign bus.south_lamp = lamp_q[1];
    assign bus.east_lamp  = lamp_q[2];
    assign bus.west_lamp  = lamp_q[3];
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
endmodule

// File: doc/traffic_safety_monitor.md
# traffic_safety_monitor

Conflict monitor that sits directly downstream of the traffic light controller. It consumes the four per-approach light vectors and re-drives them to the lamp outputs through one register stage. When it detects an unsafe or malformed pattern, it latches a fault and forces all approaches to flashing red until reset. It is the last sequential stage before the lamp drivers, so the controller's output is never trusted directly.

## Interface
Parameters:
- MIN_YELLOW, default 3: minimum consecutive cycles an approach must show yellow before red.
- FLASH_HALF, default 8: cycles per on/off half-period of fault flashing red.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- north_light, south_light, east_light, west_light  in  3 each  controller light vectors.
- north_lamp, south_lamp, east_lamp, west_lamp  out  3 each  registered lamp drives.
- fault  out  1  high while a fault is latched.
- fault_code  out  3  code of the first fault detected; 0 when no fault.

## Operation
- Light encoding is one-hot:
  - 3'b100 red
  - 3'b010 yellow
  - 3'b001 green
  - Any other value, including 3'b000, is an illegal encoding.
- Axes: north/south form axis A; east/west form axis B.
- State machine:
  - NORMAL: each lamp register loads its input each cycle.
  - FAULT: lamps are driven by the flasher.
  - NORMAL→FAULT happens on any detected violation. FAULT exits only on reset.
- Checks, all evaluated on the current inputs each cycle in NORMAL:
  - 1 CONFLICT: any axis-A approach is green or yellow while any axis-B approach is green or yellow.
  - 2 ENCODING: any input is not one-hot.
  - 3 SKIPPED_YELLOW: an approach goes from green to red.
  - 4 SHORT_YELLOW: an approach goes from yellow to red after fewer than MIN_YELLOW yellow cycles.
  - 5 SEQUENCE: an approach goes from red to yellow, or from yellow to green.
- Legal cycle per approach: green→yellow→red→green. Holding the same colour is always legal.
- Previous-colour state is held per approach. The yellow counter resets on entry to yellow, increments while yellow, and saturates at MIN_YELLOW.
- Simultaneous violations: fault_code takes the lowest-numbered code (priority 1 > 2 > 3 > 4 > 5). The code is latched and never overwritten while in FAULT.
- Flasher in FAULT:
  - All four lamps are 3'b100 for FLASH_HALF cycles, then 3'b000 for FLASH_HALF cycles, repeating.
  - The first FAULT cycle is always the "on" phase.
- Reset values:
  - All lamps 3'b100; fault 0; fault_code 0.
  - Previous colours red; yellow counters 0; flash counter 0; state NORMAL.

## Timing
- NORMAL pass-through latency is one cycle: an input at edge N appears on the lamps after edge N.
- Fault detection is combinational on the current inputs, so the violating pattern is never driven.
  - The edge that sets fault=1 also loads all lamps with 3'b100.
  - fault and fault_code rise on the same edge.
- SHORT_YELLOW boundary: yellow held exactly MIN_YELLOW cycles and then red is legal; MIN_YELLOW−1 cycles is a fault.
- Reset mid-fault: the next edge returns to the reset values above, and checking resumes the cycle after that.
- A reset asserted in the same cycle as a violation wins; no fault is latched.
- The flash counter runs 0..FLASH_HALF−1 and toggles phase on wrap. It is held at 0 outside FAULT.

## Configuration
- TRAFFIC_MONITOR_YELLOW_CHECK_EN:
  - Defined: checks 3 (SKIPPED_YELLOW), 4 (SHORT_YELLOW) and 5 (SEQUENCE) are active, along with the yellow counters and previous-colour registers.
  - Undefined: only CONFLICT and ENCODING are checked. Codes 3–5 are never produced and the counters and registers are not instantiated.
  - Lamp latency and flasher behaviour are identical either way.

## Structure
- Shared package traffic_pkg holds:
  - Light encoding constants: LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN, LIGHT_OFF.
  - Fault code constants FAULT_NONE..FAULT_SEQUENCE.
  - A helper function for one-hot legality.
- One sub-module, traffic_yellow_timer, instantiated once per approach:
  - Holds the previous colour and the yellow counter.
  - Outputs per-approach SKIPPED / SHORT / SEQUENCE flags.
  - Exists only under TRAFFIC_MONITOR_YELLOW_CHECK_EN.

## Test plan
- Reset then a legal cycle: N/S green 10 cycles → yellow 3 → red; E/W mirrors. Lamps follow with 1-cycle delay; fault stays 0.
- Conflict: north 3'b001 and east 3'b001 in the same cycle. Next edge: lamps all 3'b100, fault=1, fault_code=1. Lamps stay 3'b100 for 8 cycles, then 3'b000 for 8, repeating.
- Illegal encoding and skipped yellow in the same cycle: west 3'b011 while south goes green→red. Required: fault_code=2.
- Short yellow with MIN_YELLOW=3: yellow for 2 cycles then red gives fault_code=4. Yellow for 3 cycles then red gives no fault.
- Macro undefined: the green→red transition raises no fault. Conflict still gives fault_code=1.
- Reset asserted during flashing: next edge lamps 3'b100, fault=0, fault_code=0. A subsequent legal sequence passes through cleanly.
